// File: rtl/output_port_tx_pkg.sv
// output_port_tx_pkg: packet field positions and link FSM encoding shared by the transmit and receive sides.
// Revision 1.0
`default_nettype none

package output_port_tx_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } port_state_t;

  localparam int PAYLOAD_LSB = 0;

  // Fields are packed downward from the MSB: valid, leaf, port; addr and payload sit at the bottom.
  function automatic int valid_pos(input int packet_bits);
    return packet_bits - 1;
  endfunction

  function automatic int leaf_lsb(input int packet_bits, input int leaf_bits);
    return packet_bits - 1 - leaf_bits;
  endfunction

  function automatic int port_lsb(input int packet_bits, input int leaf_bits, input int port_bits);
    return packet_bits - 1 - leaf_bits - port_bits;
  endfunction

  function automatic int addr_lsb(input int payload_bits);
    return payload_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/output_port_tx_credit_counter.sv
// credit_counter: receiver-buffer credits, one consumed per word sent, refilled in blocks, saturating with a sticky overflow.
// Revision 1.0
`default_nettype none

module credit_counter #(
  parameter int ADDR_BITS   = 7,
  parameter int UPDATE_SIZE = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               consume,
  input  logic               replenish,
  output logic [ADDR_BITS:0] credits,
  output logic               nonzero,
  output logic               overflow
);

  // Wide enough that credits + UPDATE_SIZE never wraps before the saturation compare.
  localparam int SUM_W = ADDR_BITS + $clog2(UPDATE_SIZE + 1) + 2;
  localparam logic [SUM_W-1:0]     MAX_SUM     = SUM_W'(2 ** ADDR_BITS);
  localparam logic [ADDR_BITS:0]   MAX_CREDITS = (ADDR_BITS + 1)'(2 ** ADDR_BITS);

  logic [SUM_W-1:0] sum;

  always_comb begin
    sum = SUM_W'(credits);
    if (replenish) sum = sum + SUM_W'(UPDATE_SIZE);
    if (consume)   sum = sum - SUM_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credits  <= MAX_CREDITS;
      overflow <= 1'b0;
    end else if (sum > MAX_SUM) begin
      credits  <= MAX_CREDITS;
      overflow <= 1'b1;
    end else begin
      credits  <= sum[ADDR_BITS:0];
    end
  end

  assign nonzero = (credits != '0);

endmodule

`default_nettype wire

// File: rtl/output_port_tx.sv
// output_port_tx: packs user words into addressed packets and holds each one until the leaf arbiter accepts it.
// Revision 1.0
`default_nettype none

module output_port_tx
  import output_port_tx_pkg::*;
#(
  parameter int PACKET_BITS           = 97,
  parameter int NUM_LEAF_BITS         = 6,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int PAYLOAD_BITS          = 64,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_LEAF_BITS-1:0] dst_leaf,
  input  logic [NUM_PORT_BITS-1:0] dst_port,
  input  logic [PAYLOAD_BITS-1:0]  din_user2interface,
  input  logic                     vld_user2interface,
  output logic                     ack_interface2user,
  output logic [PACKET_BITS-1:0]   packet_from_output_port,
  input  logic                     ack_bft2interface,
  input  logic                     freespace_update,
  output logic                     credit_overflow
);

  localparam int VALID_POS = valid_pos(PACKET_BITS);
  localparam int LEAF_LSB  = leaf_lsb(PACKET_BITS, NUM_LEAF_BITS);
  localparam int PORT_LSB  = port_lsb(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS);
  localparam int ADDR_LSB  = addr_lsb(PAYLOAD_BITS);

  port_state_t              state, state_next;
  logic [NUM_ADDR_BITS-1:0] addr;
  logic [NUM_ADDR_BITS:0]   credits;
  logic [PACKET_BITS-1:0]   packet_next;
  logic                     credit_nonzero;
  logic                     transfer;

  credit_counter #(
    .ADDR_BITS   (NUM_ADDR_BITS),
    .UPDATE_SIZE (FREESPACE_UPDATE_SIZE)
  ) u_credit_counter (
    .clk       (clk),
    .reset     (reset),
    .consume   (transfer),
    .replenish (freespace_update),
    .credits   (credits),
    .nonzero   (credit_nonzero),
    .overflow  (credit_overflow)
  );

  // A new word may enter only when the output slot is empty or is being emptied this cycle.
  assign ack_interface2user = !reset && credit_nonzero &&
                              (state == IDLE || ack_bft2interface);
  assign transfer = vld_user2interface && ack_interface2user;

  always_comb begin
    state_next  = state;
    packet_next = packet_from_output_port;
    if (transfer) begin
      state_next                                       = HOLD;
      packet_next                                      = '0;
      packet_next[VALID_POS]                           = 1'b1;
      packet_next[LEAF_LSB +: NUM_LEAF_BITS]           = dst_leaf;
      packet_next[PORT_LSB +: NUM_PORT_BITS]           = dst_port;
      packet_next[ADDR_LSB +: NUM_ADDR_BITS]           = addr;
      packet_next[PAYLOAD_LSB +: PAYLOAD_BITS]         = din_user2interface;
    end else if (state == HOLD && ack_bft2interface) begin
      state_next  = IDLE;
      packet_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= IDLE;
      packet_from_output_port <= '0;
      addr                    <= '0;
    end else begin
      state                   <= state_next;
      packet_from_output_port <= packet_next;
      if (transfer) addr <= addr + NUM_ADDR_BITS'(1);
    end
  end

  // The nonzero flag is a shortcut for the full credit count; the two must never disagree.
  always_ff @(posedge clk) begin
    if (!reset) assert (credit_nonzero == (credits != '0));
  end

endmodule

`default_nettype wire
